// File: rtl/store_formatter_if.sv
// Store formatter bus bundle.
// Groups the MEM-stage request channel, the data-memory write channel,
// the address-error report and the occupancy count into one interface.
//   Request channel : in_valid/in_ready handshake, StoreOp, Addr, WriteData
//   Memory channel  : mem_valid/mem_ready handshake, mem_addr, mem_wdata, mem_be
//   Exception       : exc_valid (one-cycle pulse), exc_addr
//   Status          : pending (buffered writes, 0..2)
// The slave modport is the formatter's view; the master modport is the
// view of whatever drives requests and plays data memory.
interface store_formatter_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  StoreOp;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        exc_valid;
  logic [31:0] exc_addr;
  logic [1:0]  pending;

  modport slave (
    input  in_valid, StoreOp, Addr, WriteData, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           exc_valid, exc_addr, pending
  );

  modport master (
    output in_valid, StoreOp, Addr, WriteData, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be,
           exc_valid, exc_addr, pending
  );
endinterface

// File: rtl/store_formatter.sv
// Store formatter: turns MEM-stage SB/SH/SW requests into word-aligned,
// lane-replicated, byte-enabled writes for data memory, buffered in a
// 2-entry in-order FIFO. Misaligned SH/SW raise a one-cycle AdES report
// instead of entering the FIFO.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : store_formatter_if.slave (request, memory, exception, pending)
// Parameter:
//   BIG_ENDIAN : 1 = MIPS big-endian lane order, 0 = little-endian
module store_formatter #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  store_formatter_if.slave   bus
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SB   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1. in_ready depends only on registered occupancy, never on
  // mem_ready; mem_valid is simply "FIFO not empty".

  logic [29:0] addr_q  [2];
  logic [31:0] wdata_q [2];
  logic [3:0]  be_q    [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        exc_valid_q;
  logic [31:0] exc_addr_q;

  logic        accept;
  logic        misaligned;
  logic        push;
  logic        pop;
  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;

  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.mem_valid = (count_q != 2'd0);
  assign bus.mem_addr  = {addr_q[rd_ptr_q], 2'b00};
  assign bus.mem_wdata = wdata_q[rd_ptr_q];
  // Enables are forced low when empty so a stale slot never looks live.
  assign bus.mem_be    = bus.mem_valid ? be_q[rd_ptr_q] : 4'b0000;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_addr  = exc_addr_q;
  assign bus.pending   = count_q;

  assign accept     = bus.in_valid && bus.in_ready;
  assign misaligned = ((bus.StoreOp == OP_SH) && bus.Addr[0]) ||
                      ((bus.StoreOp == OP_SW) && (bus.Addr[1:0] != 2'b00));
  assign push       = accept && (bus.StoreOp != OP_NONE) && !misaligned;
  assign pop        = bus.mem_valid && bus.mem_ready;

  // Lane formatting. Big-endian puts byte address 0 in lane 3.
  always_comb begin
    wdata_fmt = 32'd0;
    be_fmt    = 4'b0000;
    case (bus.StoreOp)
      OP_SB: begin
        wdata_fmt = {4{bus.WriteData[7:0]}};
        be_fmt    = BIG_ENDIAN ? (4'b1000 >> bus.Addr[1:0])
                               : (4'b0001 << bus.Addr[1:0]);
      end
      OP_SH: begin
        wdata_fmt = {2{bus.WriteData[15:0]}};
        if (BIG_ENDIAN) be_fmt = bus.Addr[1] ? 4'b0011 : 4'b1100;
        else            be_fmt = bus.Addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        wdata_fmt = bus.WriteData;
        be_fmt    = 4'b1111;
      end
      default: begin
        wdata_fmt = 32'd0;
        be_fmt    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        addr_q[i]  <= 30'd0;
        wdata_q[i] <= 32'd0;
        be_q[i]    <= 4'b0000;
      end
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      exc_valid_q <= 1'b0;
      exc_addr_q  <= 32'd0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q]  <= bus.Addr[31:2];
        wdata_q[wr_ptr_q] <= wdata_fmt;
        be_q[wr_ptr_q]    <= be_fmt;
        wr_ptr_q          <= ~wr_ptr_q;  // 1-bit pointer wraps 1 -> 0
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      // AdES is a pulse: it lasts only the cycle after the bad request.
      exc_valid_q <= accept && misaligned;
      if (accept && misaligned) exc_addr_q <= bus.Addr;
    end
  end

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: one big-endian and one little-endian
// instance share clock and reset. Inputs change on the falling edge and
// outputs are checked on the falling edge, i.e. after each rising edge.
module tb_store_formatter;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  store_formatter_if sb ();
  store_formatter_if sl ();

  store_formatter #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .reset(reset), .bus(sb));
  store_formatter #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .reset(reset), .bus(sl));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_be(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    sb.in_valid = 1'b1; sb.StoreOp = op; sb.Addr = addr; sb.WriteData = wd;
  endtask

  task automatic drive_le(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    sl.in_valid = 1'b1; sl.StoreOp = op; sl.Addr = addr; sl.WriteData = wd;
  endtask

  task automatic idle_be();
    sb.in_valid = 1'b0; sb.StoreOp = 2'b00; sb.Addr = 32'd0; sb.WriteData = 32'd0;
  endtask

  task automatic idle_le();
    sl.in_valid = 1'b0; sl.StoreOp = 2'b00; sl.Addr = 32'd0; sl.WriteData = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_be(); idle_le();
    sb.mem_ready = 1'b1;
    sl.mem_ready = 1'b1;
    step(); step();
    check("rst_pending",   32'(sb.pending),   32'd0);
    check("rst_mem_valid", 32'(sb.mem_valid), 32'd0);
    check("rst_mem_be",    32'(sb.mem_be),    32'd0);
    check("rst_exc_valid", 32'(sb.exc_valid), 32'd0);
    check("rst_exc_addr",  sb.exc_addr,       32'd0);
    check("rst_in_ready",  32'(sb.in_ready),  32'd1);
    reset = 1'b0;

    // SB big-endian, byte 1 -> lane 2
    drive_be(2'b01, 32'h0000_0101, 32'h0000_00AB);
    step(); idle_be();
    check("sb_valid", 32'(sb.mem_valid), 32'd1);
    check("sb_addr",  sb.mem_addr,       32'h0000_0100);
    check("sb_wdata", sb.mem_wdata,      32'hABAB_ABAB);
    check("sb_be",    32'(sb.mem_be),    32'b0100);
    check("sb_pend",  32'(sb.pending),   32'd1);
    step();
    check("sb_drain_pend", 32'(sb.pending), 32'd0);
    check("sb_drain_be",   32'(sb.mem_be),  32'd0);

    // SB byte 0 -> lane 3; then SH upper half (Addr[1]=1) -> 0011
    drive_be(2'b01, 32'h0000_0200, 32'hFFFF_FF5A);
    step();
    check("sb0_be",    32'(sb.mem_be), 32'b1000);
    check("sb0_wdata", sb.mem_wdata,   32'h5A5A_5A5A);
    drive_be(2'b10, 32'h0000_0012, 32'hABCD_5678);
    step(); idle_be();
    check("sh_be_pend", 32'(sb.pending), 32'd1);
    check("sh_be_be",   32'(sb.mem_be),  32'b0011);
    check("sh_be_wd",   sb.mem_wdata,    32'h5678_5678);
    check("sh_be_addr", sb.mem_addr,     32'h0000_0010);
    step();
    check("sh_be_drain", 32'(sb.pending), 32'd0);

    // Misaligned SW -> one-cycle AdES, nothing buffered
    drive_be(2'b11, 32'h0000_0006, 32'hDEAD_BEEF);
    step(); idle_be();
    check("ades_valid", 32'(sb.exc_valid), 32'd1);
    check("ades_addr",  sb.exc_addr,       32'h0000_0006);
    check("ades_memv",  32'(sb.mem_valid), 32'd0);
    step();
    check("ades_pulse_end", 32'(sb.exc_valid), 32'd0);

    // Misaligned SH while a write is buffered leaves it alone; StoreOp=00 is a no-op
    sb.mem_ready = 1'b0;
    drive_be(2'b11, 32'h0000_0020, 32'h1111_1111);
    step();
    drive_be(2'b10, 32'h0000_0021, 32'h0000_2222);
    step();
    check("mis_exc",   32'(sb.exc_valid), 32'd1);
    check("mis_eaddr", sb.exc_addr,       32'h0000_0021);
    check("mis_pend",  32'(sb.pending),   32'd1);
    check("mis_wdata", sb.mem_wdata,      32'h1111_1111);
    check("mis_be",    32'(sb.mem_be),    32'b1111);
    drive_be(2'b00, 32'h0000_0040, 32'h3333_3333);
    step(); idle_be();
    check("nop_pend", 32'(sb.pending),   32'd1);
    check("nop_exc",  32'(sb.exc_valid), 32'd0);
    check("nop_addr", sb.mem_addr,       32'h0000_0020);
    sb.mem_ready = 1'b1;
    step();
    check("nop_drain", 32'(sb.pending), 32'd0);

    // Back-to-back SW with memory stalled, then drain in order
    sb.mem_ready = 1'b0;
    drive_be(2'b11, 32'h0000_0100, 32'hA0A0_A0A0);
    step();
    drive_be(2'b11, 32'h0000_0104, 32'hB0B0_B0B0);
    step();
    drive_be(2'b11, 32'h0000_0108, 32'hC0C0_C0C0);
    step();
    check("full_pend",  32'(sb.pending),  32'd2);
    check("full_ready", 32'(sb.in_ready), 32'd0);
    check("full_addr",  sb.mem_addr,      32'h0000_0100);
    step();
    check("hold_pend",  32'(sb.pending),  32'd2);
    check("hold_wdata", sb.mem_wdata,     32'hA0A0_A0A0);
    sb.mem_ready = 1'b1;
    step();
    check("drain1_pend",  32'(sb.pending),  32'd1);
    check("drain1_addr",  sb.mem_addr,      32'h0000_0104);
    check("drain1_ready", 32'(sb.in_ready), 32'd1);
    step(); idle_be();   // push C and pop B on the same edge
    check("pushpop_pend",  32'(sb.pending), 32'd1);
    check("pushpop_addr",  sb.mem_addr,     32'h0000_0108);
    check("pushpop_wdata", sb.mem_wdata,    32'hC0C0_C0C0);
    step();
    check("drain_end_pend", 32'(sb.pending),   32'd0);
    check("drain_end_memv", 32'(sb.mem_valid), 32'd0);

    // Fill, then reset with a request presented in the reset cycle
    sb.mem_ready = 1'b0;
    drive_be(2'b11, 32'h0000_0200, 32'h1234_5678);
    step();
    drive_be(2'b11, 32'h0000_0204, 32'h8765_4321);
    step();
    check("pre_rst_pend", 32'(sb.pending), 32'd2);
    reset = 1'b1;
    drive_be(2'b11, 32'h0000_0300, 32'h5555_5555);
    step();
    reset = 1'b0; idle_be(); sb.mem_ready = 1'b1;
    check("mid_rst_pend",  32'(sb.pending),   32'd0);
    check("mid_rst_memv",  32'(sb.mem_valid), 32'd0);
    check("mid_rst_ready", 32'(sb.in_ready),  32'd1);
    check("mid_rst_be",    32'(sb.mem_be),    32'd0);
    step();
    check("post_rst_memv", 32'(sb.mem_valid), 32'd0);

    // Exception pending when reset hits is discarded
    drive_be(2'b10, 32'h0000_0041, 32'h0);
    step(); idle_be();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_exc_clear", 32'(sb.exc_valid), 32'd0);
    check("rst_eaddr_clr", sb.exc_addr,       32'd0);

    // Little-endian instance
    drive_le(2'b10, 32'h0000_0010, 32'h0000_1234);
    step();
    check("le_sh_wdata", sl.mem_wdata,   32'h1234_1234);
    check("le_sh_be",    32'(sl.mem_be), 32'b0011);
    drive_le(2'b01, 32'h0000_0101, 32'h0000_00CD);
    step();
    check("le_sb_be",    32'(sl.mem_be), 32'b0010);
    check("le_sb_wdata", sl.mem_wdata,   32'hCDCD_CDCD);
    drive_le(2'b10, 32'h0000_0012, 32'h0000_BEEF);
    step(); idle_le();
    check("le_sh_hi_be", 32'(sl.mem_be), 32'b1100);
    step();
    check("le_drain", 32'(sl.pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_formatter.md
STORE_FORMATTER -- requirements
Module: store_formatter

Interface
REQ-001 SHALL have parameter BIG_ENDIAN, default 1, selecting byte-lane order: 1 = MIPS big-endian, 0 = little-endian.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  a store request from the MEM stage is present.
REQ-005 SHALL have port in_ready  output  1  the block accepts a request this cycle.
REQ-006 SHALL have port StoreOp  input  2  request type: 00 none, 01 SB, 10 SH, 11 SW.
REQ-007 SHALL have port Addr  input  32  byte address of the store.
REQ-008 SHALL have port WriteData  input  32  register data to store; only the low bits are used for SB and SH.
REQ-009 SHALL have port mem_valid  output  1  a formatted write is offered to data memory.
REQ-010 SHALL have port mem_ready  input  1  data memory accepts the offered write.
REQ-011 SHALL have port mem_addr  output  32  word-aligned address, {Addr[31:2],2'b00}.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-014 SHALL have port exc_valid  output  1  one-cycle address-error-on-store (AdES) pulse.
REQ-015 SHALL have port exc_addr  output  32  the faulting byte address, valid while exc_valid is 1.
REQ-016 SHALL have port pending  output  2  number of buffered writes, 0..2.

Function
REQ-017 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 whenever pending < 2 and SHALL be 0 when pending = 2; it SHALL NOT depend combinationally on mem_ready.
REQ-019 The block SHALL hold accepted, aligned SB/SH/SW requests in a 2-entry FIFO, with entries leaving in order.
REQ-020 mem_valid SHALL equal (pending != 0); mem_addr, mem_wdata and mem_be SHALL come from the head entry and stay stable while mem_valid=1 and mem_ready=0.
REQ-021 The head entry SHALL be popped on an edge where mem_valid and mem_ready are both 1.
REQ-022 Latency SHALL be 1: a request accepted into an empty FIFO appears on the mem_* outputs in the following cycle; there is no combinational bypass.
REQ-023 A simultaneous push and pop SHALL leave pending unchanged and preserve order. A push with no pop SHALL increment pending, and a pop with no push SHALL decrement it.
REQ-024 SB SHALL set mem_wdata = {4{WriteData[7:0]}}; mem_be SHALL have one bit set, at lane 3-Addr[1:0] when BIG_ENDIAN=1 or lane Addr[1:0] when BIG_ENDIAN=0.
REQ-025 SH SHALL set mem_wdata = {2{WriteData[15:0]}}.
REQ-026 For SH with BIG_ENDIAN=1, mem_be SHALL be 1100 for Addr[1]=0 and 0011 for Addr[1]=1; with BIG_ENDIAN=0 these values are swapped.
REQ-027 SW SHALL set mem_wdata = WriteData and mem_be = 1111.
REQ-028 A request with StoreOp=00, when accepted, SHALL be consumed with no FIFO entry and no exception.
REQ-029 An accepted SH with Addr[0]=1, or SW with Addr[1:0]!=00, SHALL be misaligned.
REQ-030 A misaligned request SHALL NOT enter the FIFO and SHALL produce exc_valid=1 with exc_addr=Addr for exactly the next cycle.
REQ-031 exc_valid SHALL be 0 whenever no misaligned request was accepted in the previous cycle.
REQ-032 A misaligned request SHALL NOT disturb any write already buffered in the FIFO.
REQ-033 mem_be SHALL be 0000 whenever mem_valid=0.
REQ-034 The FIFO read and write pointers SHALL each be 1 bit wide and SHALL wrap from 1 to 0.

Reset
REQ-035 While reset=1 at an edge, pending SHALL become 0 and the pointers 0, giving mem_valid=0, mem_be=0000, exc_valid=0, exc_addr=0 and in_ready=1 in the next cycle.
REQ-036 Reset asserted mid-operation SHALL discard all buffered writes and any pending exception.
REQ-037 A request presented in the same cycle as reset SHALL be ignored.

Verification
REQ-038 Scenario: SB, Addr=0x00000101, WriteData=0x000000AB, BIG_ENDIAN=1, mem_ready=1 -> next cycle mem_addr=0x00000100, mem_wdata=0xABABABAB, mem_be=0100, pending=1.
REQ-039 Scenario: SH at Addr=0x10, WriteData=0x1234, BIG_ENDIAN=0 -> mem_wdata=0x12341234, mem_be=0011.
REQ-040 Scenario: SW at Addr=0x00000006 -> the next cycle has exc_valid=1 and exc_addr=0x00000006, mem_valid stays 0, and exc_valid is 0 one cycle later.
REQ-041 Scenario: mem_ready=0 with three back-to-back SW requests -> pending=2, in_ready=0, and the third request is held. With mem_ready=1 the writes drain in order, the third request is accepted once in_ready returns to 1, and pending returns to 0.
REQ-042 Scenario: FIFO full, reset pulsed for one cycle -> pending=0, mem_valid=0 and in_ready=1 on the next cycle, and no buffered write is ever issued.
REQ-043 Scenario: pending=1 with a simultaneous accept and pop on one edge -> pending stays 1 and the new entry appears at the head on the next cycle.
